// File: rtl/eth_cfg_regs_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the
// Ethernet/UDP stack configuration register bank.
package eth_cfg_regs_pkg;

  localparam logic [3:0] OFF_ID      = 4'h0;
  localparam logic [3:0] OFF_CTRL    = 4'h1;
  localparam logic [3:0] OFF_MAC_LO  = 4'h2;
  localparam logic [3:0] OFF_MAC_HI  = 4'h3;
  localparam logic [3:0] OFF_IP      = 4'h4;
  localparam logic [3:0] OFF_GATEWAY = 4'h5;
  localparam logic [3:0] OFF_SUBNET  = 4'h6;
  localparam logic [3:0] OFF_STATUS  = 4'h7;
  localparam logic [3:0] OFF_FCS_CNT = 4'h8;
  localparam logic [3:0] OFF_OVF_CNT = 4'h9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int CTRL_SCREAMER = 0;
  localparam int CTRL_CLR_ARP  = 1;
  localparam int CTRL_CLR_CNT  = 2;
  localparam int STATUS_FCS    = 0;
  localparam int STATUS_OVF    = 1;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter; clear and increment together yield 1.
// One-cycle update latency, no backpressure.
module sat_event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/eth_cfg_axil_regs.sv
// AXI-Lite register bank configuring/monitoring the Ethernet/UDP stack.
// B/R valid one cycle after the completing handshake; responses held until bready/rready.
module eth_cfg_axil_regs
  import eth_cfg_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE      = 32'h4554_0001,
  parameter logic [47:0] RESET_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [31:0] RESET_IP      = 32'hC0A8_0180,
  parameter logic [31:0] RESET_GATEWAY = 32'hC0A8_0101,
  parameter logic [31:0] RESET_SUBNET  = 32'hFFFF_FF00,
  parameter int          ADDR_WIDTH    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] axil_awaddr,
  input  logic                  axil_awvalid,
  output logic                  axil_awready,
  input  logic [31:0]           axil_wdata,
  input  logic [3:0]            axil_wstrb,
  input  logic                  axil_wvalid,
  output logic                  axil_wready,
  output logic [1:0]            axil_bresp,
  output logic                  axil_bvalid,
  input  logic                  axil_bready,
  input  logic [ADDR_WIDTH-1:0] axil_araddr,
  input  logic                  axil_arvalid,
  output logic                  axil_arready,
  output logic [31:0]           axil_rdata,
  output logic [1:0]            axil_rresp,
  output logic                  axil_rvalid,
  input  logic                  axil_rready,
  input  logic                  bad_fcs,
  input  logic                  fifo_overflow,
  output logic [47:0]           local_mac,
  output logic [31:0]           local_ip,
  output logic [31:0]           gateway_ip,
  output logic [31:0]           subnet_mask,
  output logic                  clear_arp_cache,
  output logic                  screamer_enable
);

  wr_state_t   wr_state;
  rd_state_t   rd_state;
  logic        aw_held, w_held, aw_hs, w_hs, wr_fire, wr_ok, clr_cnt;
  logic [3:0]  aw_off_q, wr_strb_q, wr_off, wr_strb, rd_off;
  logic [31:0] wr_dat_q, wr_dat, mac_hi_wr, rd_dat, fcs_cnt, ovf_cnt;
  logic [1:0]  wr_resp, rd_resp, sticky, sticky_clr;
  logic        unused_addr;

  assign unused_addr = ^{axil_awaddr, axil_araddr};

  // The completing channel may be presented this cycle, so merge held and live beats.
  always_comb begin
    aw_hs   = axil_awvalid & axil_awready;
    w_hs    = axil_wvalid & axil_wready;
    wr_off  = aw_held ? aw_off_q : axil_awaddr[5:2];
    wr_dat  = w_held ? wr_dat_q : axil_wdata;
    wr_strb = w_held ? wr_strb_q : axil_wstrb;
    wr_fire = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    case (wr_off)
      OFF_ID, OFF_FCS_CNT, OFF_OVF_CNT: wr_resp = RESP_SLVERR;
      OFF_CTRL, OFF_MAC_LO, OFF_MAC_HI, OFF_IP,
      OFF_GATEWAY, OFF_SUBNET, OFF_STATUS: wr_resp = RESP_OKAY;
      default: wr_resp = RESP_DECERR;
    endcase
    wr_ok      = wr_fire && (wr_resp == RESP_OKAY);
    clr_cnt    = wr_ok && (wr_off == OFF_CTRL) && wr_strb[0] && wr_dat[CTRL_CLR_CNT];
    sticky_clr = (wr_ok && (wr_off == OFF_STATUS) && wr_strb[0])
                 ? wr_dat[STATUS_OVF:STATUS_FCS] : 2'b00;
    mac_hi_wr  = apply_strb({16'h0, local_mac[47:32]}, wr_dat, {2'b00, wr_strb[1:0]});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state     <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_off_q     <= '0;
      wr_dat_q     <= '0;
      wr_strb_q    <= '0;
      axil_awready <= 1'b1;
      axil_wready  <= 1'b1;
      axil_bvalid  <= 1'b0;
      axil_bresp   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held      <= 1'b1;
            aw_off_q     <= axil_awaddr[5:2];
            axil_awready <= 1'b0;
          end
          if (w_hs) begin
            w_held      <= 1'b1;
            wr_dat_q    <= axil_wdata;
            wr_strb_q   <= axil_wstrb;
            axil_wready <= 1'b0;
          end
          if (wr_fire) begin
            wr_state     <= W_RESP;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            axil_awready <= 1'b0;
            axil_wready  <= 1'b0;
            axil_bvalid  <= 1'b1;
            axil_bresp   <= wr_resp;
          end
        end
        W_RESP: begin
          if (axil_bready) begin
            wr_state     <= W_IDLE;
            axil_bvalid  <= 1'b0;
            axil_awready <= 1'b1;
            axil_wready  <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      local_mac       <= RESET_MAC;
      local_ip        <= RESET_IP;
      gateway_ip      <= RESET_GATEWAY;
      subnet_mask     <= RESET_SUBNET;
      screamer_enable <= 1'b0;
      clear_arp_cache <= 1'b0;
      sticky          <= 2'b00;
    end else begin
      clear_arp_cache <= wr_ok && (wr_off == OFF_CTRL) && wr_strb[0] && wr_dat[CTRL_CLR_ARP];
      // Event OR-ed in after the W1C mask so a coincident event wins.
      sticky <= (sticky & ~sticky_clr) | {fifo_overflow, bad_fcs};
      if (wr_ok) begin
        case (wr_off)
          OFF_CTRL:    if (wr_strb[0]) screamer_enable <= wr_dat[CTRL_SCREAMER];
          OFF_MAC_LO:  local_mac[31:0] <= apply_strb(local_mac[31:0], wr_dat, wr_strb);
          OFF_MAC_HI:  local_mac[47:32] <= mac_hi_wr[15:0];
          OFF_IP:      local_ip <= apply_strb(local_ip, wr_dat, wr_strb);
          OFF_GATEWAY: gateway_ip <= apply_strb(gateway_ip, wr_dat, wr_strb);
          OFF_SUBNET:  subnet_mask <= apply_strb(subnet_mask, wr_dat, wr_strb);
          default: ;
        endcase
      end
    end
  end

  sat_event_counter #(.WIDTH(32)) u_fcs_cnt (
    .clk(clk), .reset(reset), .inc(bad_fcs), .clr(clr_cnt), .count(fcs_cnt)
  );

  sat_event_counter #(.WIDTH(32)) u_ovf_cnt (
    .clk(clk), .reset(reset), .inc(fifo_overflow), .clr(clr_cnt), .count(ovf_cnt)
  );

  always_comb begin
    rd_off  = axil_araddr[5:2];
    rd_resp = RESP_OKAY;
    case (rd_off)
      OFF_ID:      rd_dat = ID_VALUE;
      OFF_CTRL:    rd_dat = {31'b0, screamer_enable};
      OFF_MAC_LO:  rd_dat = local_mac[31:0];
      OFF_MAC_HI:  rd_dat = {16'b0, local_mac[47:32]};
      OFF_IP:      rd_dat = local_ip;
      OFF_GATEWAY: rd_dat = gateway_ip;
      OFF_SUBNET:  rd_dat = subnet_mask;
      OFF_STATUS:  rd_dat = {30'b0, sticky};
      OFF_FCS_CNT: rd_dat = fcs_cnt;
      OFF_OVF_CNT: rd_dat = ovf_cnt;
      default: begin
        rd_dat  = 32'h0;
        rd_resp = RESP_DECERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state     <= R_IDLE;
      axil_arready <= 1'b1;
      axil_rvalid  <= 1'b0;
      axil_rdata   <= '0;
      axil_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (axil_arvalid) begin
            rd_state     <= R_DATA;
            axil_arready <= 1'b0;
            axil_rvalid  <= 1'b1;
            axil_rdata   <= rd_dat;
            axil_rresp   <= rd_resp;
          end
        end
        R_DATA: begin
          if (axil_rready) begin
            rd_state     <= R_IDLE;
            axil_rvalid  <= 1'b0;
            axil_arready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
